select_encode_seq: RTL and testbench
====================================

// Module: select_encode_seq
// PURPOSE
//  Control-side driver for the register-file bus protocol: decodes a latched IR and sequences
//  the Rout/Rin one-hot strobes, BAout, and datapath enables for the ld/ldi/st address phase.
//  It is the producer of R0in/Rout/BAout; with BAout high, R0 reads as 0 on the bus.
//  Sits between the control unit (start/done handshake) and the 16-register datapath.
// PARAMETERS
//  NREGS   16  number of GP registers; width of Rout/Rin; IR reg fields are log2(NREGS)=4 bits
//  OP_LD   5'b00000  ld opcode  | OP_LDI 5'b00001 ldi opcode | OP_ST 5'b00010 st opcode
// PORTS
//  clock    in   1      rising-edge clock
//  clear    in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  ir       in   32     [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:0] C (C driven by datapath)
//  busy     out  1      high from cycle after accepted start through DONE/ERR cycle inclusive
//  done     out  1      1-cycle pulse: sequence complete
//  err      out  1      1-cycle pulse, same cycle as done, for illegal opcode
//  Rout     out  NREGS  one-hot register-to-bus select
//  Rin      out  NREGS  one-hot bus-to-register write enable
//  BAout    out  1      base-address mode: R0 drives 0 onto bus
//  Yin, Cout, ALU_add, Zin, Zlowout, MARin, MDRin  out 1 each  datapath strobes
// BEHAVIOUR
//  - clear=0: state=IDLE, every output 0 immediately (async); held-IR cleared to 0.
//  - Reset mid-sequence aborts; no partial strobes after clear deasserts; restart needs new start.
//  - IDLE: outputs 0. start=1 at edge -> latch ir into IRq, go BASE (legal op) or ERR.
//  - start while busy=1 ignored; ir changes after accept have no effect (IRq used).
//  - States/outputs (all strobes Moore, decoded from state + IRq):
//    BASE   : Rout[Rb]=1, BAout=1, Yin=1 -> OFFSET   (Rb=0 gives base 0 via R0 gating)
//    OFFSET : Cout=1, ALU_add=1, Zin=1    -> ZLO
//    ZLO    : Zlowout=1; ld/st: MARin=1; ldi: Rin[Ra]=1 -> STDATA (st, STORE_DATA_EN) else DONE
//    STDATA : Rout[Ra]=1, MDRin=1, BAout=0 -> DONE
//    DONE   : done=1, busy=1 -> IDLE       | ERR: done=1, err=1, busy=1, no strobes -> IDLE
//  - Latency start-edge to done: ld/ldi/st 4 cycles (st 5 with STORE_DATA_EN); illegal 1 cycle.
//  - Rout/Rin strictly one-hot or zero; never both Rout and Rin bits in the same cycle except
//    none. BAout asserted only in BASE.
//  - Opcodes other than OP_LD/OP_LDI/OP_ST are illegal.
//  - start in the DONE/ERR cycle is ignored (accept only in IDLE; min 1 idle cycle between ops).
//  - Register index fields use low log2(NREGS) bits; no wrap or out-of-range handling needed.
// CONFIGURATION
//  STORE_DATA_EN defined: st inserts STDATA after ZLO (Ra to MDR); st latency 5 cycles.
//  STORE_DATA_EN undefined: STDATA state absent; st identical to ld (address only, 4 cycles),
//    MDRin tied 0.
// TESTING
//  1 clear=0 mid-OFFSET of ld -> all outputs 0 same cycle; after clear=1, stays IDLE, busy=0.
//  2 ld ir=0x00880000 (Ra=1,Rb=1): start -> BASE Rout=0x0002 BAout=1 Yin=1; OFFSET; ZLO
//    Zlowout=1 MARin=1; done pulse on cycle 4; Rin=0 throughout.
//  3 ldi Ra=5, Rb=0 (ir=0x0A800000): BASE Rout=0x0001 BAout=1; ZLO Rin=0x0020; done cycle 4.
//  4 st Ra=3,Rb=2 with STORE_DATA_EN: STDATA Rout=0x0008 MDRin=1 BAout=0; done cycle 5;
//    without macro: done cycle 4, MDRin never 1.
//  5 opcode 5'b11111 start -> next cycle done=1 err=1, no strobes, then busy=0.
//  6 start held high and ir changed during ld -> one sequence only, strobes follow first ir;
//    start during DONE ignored, accepted next IDLE cycle.

Source files
------------

// File: rtl/select_encode_seq.sv
// -----------------------------------------------------------------------------
// select_encode_seq
//  Control-side sequencer for the register-file bus. It latches the IR when a
//  request is accepted, decodes the ld/ldi/st address phase, and drives the
//  one-hot Rout/Rin strobes, BAout and the datapath enables. With BAout high,
//  R0 reads as 0 on the bus, so Rb=0 gives a base of 0.
//
//  Optional feature macro: STORE_DATA_EN
//    defined   : st adds an STDATA cycle after ZLO (Ra -> MDR), 5-cycle latency
//    undefined : st behaves like ld (address only), MDRin tied to 0
//
// Ports
//  clock    in   rising-edge clock
//  clear    in   asynchronous active-low reset
//  start    in   request, sampled only in IDLE
//  ir       in   [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:0] C (unused here)
//  busy     out  high in every non-IDLE state
//  done     out  one-cycle completion pulse
//  err      out  one-cycle pulse alongside done for an illegal opcode
//  Rout     out  one-hot register-to-bus select
//  Rin      out  one-hot bus-to-register write enable
//  BAout    out  base-address mode (R0 drives 0)
//  Yin, Cout, ALU_add, Zin, Zlowout, MARin, MDRin  out  datapath strobes
// -----------------------------------------------------------------------------
module select_encode_seq #(
   parameter int         NREGS  = 16,
   parameter logic [4:0] OP_LD  = 5'b00000,
   parameter logic [4:0] OP_LDI = 5'b00001,
   parameter logic [4:0] OP_ST  = 5'b00010
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [31:0]      ir,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [NREGS-1:0] Rout,
   output logic [NREGS-1:0] Rin,
   output logic             BAout,
   output logic             Yin,
   output logic             Cout,
   output logic             ALU_add,
   output logic             Zin,
   output logic             Zlowout,
   output logic             MARin,
   output logic             MDRin
);

   localparam int IW = $clog2(NREGS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BASE   = 3'd1,
      S_OFFSET = 3'd2,
      S_ZLO    = 3'd3,
`ifdef STORE_DATA_EN
      S_STDATA = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t state_q, state_d;

   // Held IR: only opcode and register fields are needed after accept.
   logic [4:0]    op_q, op_d;
   logic [IW-1:0] ra_q, ra_d;
   logic [IW-1:0] rb_q, rb_d;

   logic             busy_d, done_d, err_d, baout_d, yin_d, cout_d;
   logic             add_d, zin_d, zlo_d, marin_d;
   logic [NREGS-1:0] rout_d, rin_d;
   logic             busy_q, done_q, err_q, baout_q, yin_q, cout_q;
   logic             add_q, zin_q, zlo_q, marin_q;
   logic [NREGS-1:0] rout_q, rin_q;

   function automatic logic is_legal_op(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

   function automatic logic [NREGS-1:0] onehot(input logic [IW-1:0] idx);
      return {{(NREGS-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Next-state and held-IR update.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = ir[31:27];
               ra_d = ir[26 -: IW];
               rb_d = ir[22 -: IW];
               if (is_legal_op(ir[31:27])) begin
                  state_d = S_BASE;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BASE:   state_d = S_OFFSET;
         S_OFFSET: state_d = S_ZLO;
         S_ZLO: begin
`ifdef STORE_DATA_EN
            if (op_q == OP_ST) begin
               state_d = S_STDATA;
            end else begin
               state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
         end
`ifdef STORE_DATA_EN
         S_STDATA: state_d = S_DONE;
`endif
         S_DONE:   state_d = S_IDLE;
         S_ERR:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and held-IR registers.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         op_q    <= 5'd0;
         ra_q    <= {IW{1'b0}};
         rb_q    <= {IW{1'b0}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
      end
   end

   // Output decode from the upcoming state, so the registered strobes line up
   // with the state they belong to.
   always_comb begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      baout_d = 1'b0;
      yin_d   = 1'b0;
      cout_d  = 1'b0;
      add_d   = 1'b0;
      zin_d   = 1'b0;
      zlo_d   = 1'b0;
      marin_d = 1'b0;
      rout_d  = {NREGS{1'b0}};
      rin_d   = {NREGS{1'b0}};
      case (state_d)
         S_IDLE: busy_d = 1'b0;
         S_BASE: begin
            busy_d  = 1'b1;
            rout_d  = onehot(rb_d);
            baout_d = 1'b1;
            yin_d   = 1'b1;
         end
         S_OFFSET: begin
            busy_d = 1'b1;
            cout_d = 1'b1;
            add_d  = 1'b1;
            zin_d  = 1'b1;
         end
         S_ZLO: begin
            busy_d = 1'b1;
            zlo_d  = 1'b1;
            // Only legal opcodes reach ZLO: ldi writes Ra, ld/st load MAR.
            if (op_d == OP_LDI) begin
               rin_d = onehot(ra_d);
            end else begin
               marin_d = 1'b1;
            end
         end
`ifdef STORE_DATA_EN
         S_STDATA: begin
            busy_d = 1'b1;
            rout_d = onehot(ra_d);
         end
`endif
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         S_ERR: begin
            busy_d = 1'b1;
            done_d = 1'b1;
            err_d  = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Output registers, cleared asynchronously with the state.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         baout_q <= 1'b0;
         yin_q   <= 1'b0;
         cout_q  <= 1'b0;
         add_q   <= 1'b0;
         zin_q   <= 1'b0;
         zlo_q   <= 1'b0;
         marin_q <= 1'b0;
         rout_q  <= {NREGS{1'b0}};
         rin_q   <= {NREGS{1'b0}};
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         baout_q <= baout_d;
         yin_q   <= yin_d;
         cout_q  <= cout_d;
         add_q   <= add_d;
         zin_q   <= zin_d;
         zlo_q   <= zlo_d;
         marin_q <= marin_d;
         rout_q  <= rout_d;
         rin_q   <= rin_d;
      end
   end

`ifdef STORE_DATA_EN
   logic mdrin_q;

   // MDR load strobe, only present when the store-data cycle exists.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         mdrin_q <= 1'b0;
      end else begin
         mdrin_q <= (state_d == S_STDATA);
      end
   end

   assign MDRin = mdrin_q;
`else
   assign MDRin = 1'b0;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign BAout   = baout_q;
   assign Yin     = yin_q;
   assign Cout    = cout_q;
   assign ALU_add = add_q;
   assign Zin     = zin_q;
   assign Zlowout = zlo_q;
   assign MARin   = marin_q;
   assign Rout    = rout_q;
   assign Rin     = rin_q;

endmodule

// File: tb/tb_select_encode_seq.sv
// -----------------------------------------------------------------------------
// tb_select_encode_seq
//  Directed bench for select_encode_seq. Control strobes are packed as
//  {busy,done,err,BAout,Yin,Cout,ALU_add,Zin,Zlowout,MARin,MDRin}.
// -----------------------------------------------------------------------------
module tb_select_encode_seq;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] ir;
   logic        busy, done, err, BAout, Yin, Cout, ALU_add, Zin, Zlowout, MARin, MDRin;
   logic [15:0] Rout, Rin;

   int n_vec;
   int n_miss;

   localparam logic [10:0] C_IDLE  = 11'h000;
   localparam logic [10:0] C_BASE  = 11'h4C0;
   localparam logic [10:0] C_OFF   = 11'h438;
   localparam logic [10:0] C_ZLO_M = 11'h406;
   localparam logic [10:0] C_ZLO_I = 11'h404;
   localparam logic [10:0] C_STD   = 11'h401;
   localparam logic [10:0] C_DONE  = 11'h600;
   localparam logic [10:0] C_ERR   = 11'h700;

   select_encode_seq dut (
      .clock   (clock),
      .clear   (clear),
      .start   (start),
      .ir      (ir),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .Rout    (Rout),
      .Rin     (Rin),
      .BAout   (BAout),
      .Yin     (Yin),
      .Cout    (Cout),
      .ALU_add (ALU_add),
      .Zin     (Zin),
      .Zlowout (Zlowout),
      .MARin   (MARin),
      .MDRin   (MDRin)
   );

   // 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_cycle(input string tag, input logic [10:0] ctl,
                            input logic [15:0] rout_e, input logic [15:0] rin_e);
      check({tag, ".ctl"}, {21'd0, busy, done, err, BAout, Yin, Cout, ALU_add, Zin,
                            Zlowout, MARin, MDRin}, {21'd0, ctl});
      check({tag, ".rout"}, {16'd0, Rout}, {16'd0, rout_e});
      check({tag, ".rin"}, {16'd0, Rin}, {16'd0, rin_e});
   endtask

   // Sample 1 ns after the rising edge; inputs change right after sampling.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One accepted legal sequence; start is dropped after the accepting edge.
   task automatic run_legal(input string tag, input logic [31:0] ir_v,
                            input logic [15:0] rout_base, input logic [10:0] zlo_ctl,
                            input logic [15:0] rin_zlo, input bit has_std,
                            input logic [15:0] rout_std);
      start = 1'b1;
      ir    = ir_v;
      tick();
      start = 1'b0;
      chk_cycle({tag, ".base"}, C_BASE, rout_base, 16'h0000);
      tick();
      chk_cycle({tag, ".offset"}, C_OFF, 16'h0000, 16'h0000);
      tick();
      chk_cycle({tag, ".zlo"}, zlo_ctl, 16'h0000, rin_zlo);
      if (has_std) begin
         tick();
         chk_cycle({tag, ".stdata"}, C_STD, rout_std, 16'h0000);
      end else begin
         n_vec = n_vec;
      end
      tick();
      chk_cycle({tag, ".done"}, C_DONE, 16'h0000, 16'h0000);
      tick();
      chk_cycle({tag, ".idle"}, C_IDLE, 16'h0000, 16'h0000);
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      start  = 1'b0;
      ir     = 32'h0000_0000;
      clear  = 1'b1;
      #2 clear = 1'b0;
      #1;
      chk_cycle("reset", C_IDLE, 16'h0000, 16'h0000);
      tick();
      tick();
      clear = 1'b1;
      tick();
      chk_cycle("post_reset_idle", C_IDLE, 16'h0000, 16'h0000);

      // ld Ra=1 Rb=1
      run_legal("ld", 32'h0088_0000, 16'h0002, C_ZLO_M, 16'h0000, 1'b0, 16'h0000);

      // ldi Ra=5 Rb=0: base comes from R0 with BAout
      run_legal("ldi", 32'h0A80_0000, 16'h0001, C_ZLO_I, 16'h0020, 1'b0, 16'h0000);

      // ldi Ra=15 Rb=15: top register index
      run_legal("ldi15", 32'h0FF8_0000, 16'h8000, C_ZLO_I, 16'h8000, 1'b0, 16'h0000);

      // st Ra=3 Rb=2
`ifdef STORE_DATA_EN
      run_legal("st", 32'h1190_0000, 16'h0004, C_ZLO_M, 16'h0000, 1'b1, 16'h0008);
`else
      run_legal("st", 32'h1190_0000, 16'h0004, C_ZLO_M, 16'h0000, 1'b0, 16'h0000);
`endif

      // Illegal opcode 5'b11111
      start = 1'b1;
      ir    = 32'hF800_0000;
      tick();
      start = 1'b0;
      chk_cycle("illegal.err", C_ERR, 16'h0000, 16'h0000);
      tick();
      chk_cycle("illegal.idle", C_IDLE, 16'h0000, 16'h0000);

      // Reset in the middle of OFFSET of an ld
      start = 1'b1;
      ir    = 32'h0088_0000;
      tick();
      start = 1'b0;
      chk_cycle("abort.base", C_BASE, 16'h0002, 16'h0000);
      tick();
      chk_cycle("abort.offset", C_OFF, 16'h0000, 16'h0000);
      #2 clear = 1'b0;
      #1;
      chk_cycle("abort.cleared", C_IDLE, 16'h0000, 16'h0000);
      tick();
      clear = 1'b1;
      tick();
      chk_cycle("abort.idle1", C_IDLE, 16'h0000, 16'h0000);
      tick();
      chk_cycle("abort.idle2", C_IDLE, 16'h0000, 16'h0000);

      // start held high, ir changed after accept, start present during DONE
      start = 1'b1;
      ir    = 32'h0088_0000;
      tick();
      chk_cycle("hold.base", C_BASE, 16'h0002, 16'h0000);
      ir = 32'h0A80_0000;
      tick();
      chk_cycle("hold.offset", C_OFF, 16'h0000, 16'h0000);
      tick();
      chk_cycle("hold.zlo", C_ZLO_M, 16'h0000, 16'h0000);
      tick();
      chk_cycle("hold.done", C_DONE, 16'h0000, 16'h0000);
      tick();
      chk_cycle("hold.idle", C_IDLE, 16'h0000, 16'h0000);
      tick();
      start = 1'b0;
      chk_cycle("hold.base2", C_BASE, 16'h0001, 16'h0000);
      tick();
      chk_cycle("hold.offset2", C_OFF, 16'h0000, 16'h0000);
      tick();
      chk_cycle("hold.zlo2", C_ZLO_I, 16'h0000, 16'h0020);
      tick();
      chk_cycle("hold.done2", C_DONE, 16'h0000, 16'h0000);
      tick();
      chk_cycle("hold.idle2", C_IDLE, 16'h0000, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
